// File: rtl/comp_4_pkg.sv
// Shared constants and FSM encoding for the 4-bit comparator exerciser.
package comp_4_pkg;

  localparam int VEC_W = 4;

  // {K,L} result codes driven by a COMP_4-style responder
  localparam logic [1:0] KL_GT  = 2'b10;
  localparam logic [1:0] KL_LT  = 2'b01;
  localparam logic [1:0] KL_EQ  = 2'b11;
  localparam logic [1:0] KL_BAD = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

endpackage

// File: rtl/comp_4_ref.sv
// Golden comparator model: operands in, expected {K,L} out. Never yields KL_BAD.
module comp_4_ref
  import comp_4_pkg::*;
(
  input  logic [VEC_W-1:0] i_x,
  input  logic [VEC_W-1:0] i_y,
  output logic [1:0]       o_kl
);

  always_comb begin
    o_kl = KL_EQ;
    if (i_x > i_y)      o_kl = KL_GT;
    else if (i_x < i_y) o_kl = KL_LT;
  end

endmodule

// File: rtl/comp_4_exerciser.sv
// Self-test initiator: sweeps all 256 X/Y pairs into a comparator, checks K/L
// against the golden code, and reports mismatch count and first failing vector.
module comp_4_exerciser
  import comp_4_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int ERR_W      = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  output logic [VEC_W-1:0] X_o,
  output logic [VEC_W-1:0] Y_o,
  input  logic             K_i,
  input  logic             L_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [7:0]       first_err_o,
  output logic             first_err_vld_o
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_idx;
  logic [3:0]       r_settle;
  logic [VEC_W-1:0] r_x, r_y;
  logic             r_busy, r_done;
  logic [ERR_W-1:0] r_err_cnt;
  logic [7:0]       r_first_err;
  logic             r_first_vld;
  logic [1:0]       w_exp;
  logic             w_mis;
  logic             w_start;

  comp_4_ref u_ref (
    .i_x  (r_x),
    .i_y  (r_y),
    .o_kl (w_exp)
  );

  // An illegal 00 code can never equal w_exp, so it always counts as a mismatch
  assign w_mis   = ({K_i, L_i} != w_exp);
  assign w_start = start_i && (r_state == ST_IDLE || r_state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start_i) w_state_nxt = ST_APPLY;
      ST_APPLY:  w_state_nxt = ST_SETTLE;
      ST_SETTLE: if (r_settle == 4'd0) w_state_nxt = ST_CHECK;
      ST_CHECK:  w_state_nxt = (r_idx == 8'hFF) ? ST_DONE : ST_APPLY;
      ST_DONE:   if (start_i) w_state_nxt = ST_APPLY;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= 8'd0;
      r_settle    <= 4'd0;
      r_x         <= '0;
      r_y         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_cnt   <= '0;
      r_first_err <= 8'd0;
      r_first_vld <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start) begin
            r_idx       <= 8'd0;
            r_err_cnt   <= '0;
            r_first_err <= 8'd0;
            r_first_vld <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end
        end
        ST_APPLY: begin
          r_x      <= r_idx[7:4];
          r_y      <= r_idx[3:0];
          r_settle <= SETTLE_LD;
        end
        ST_SETTLE: begin
          if (r_settle != 4'd0) r_settle <= r_settle - 4'd1;
        end
        ST_CHECK: begin
          if (w_mis) begin
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_W'(1);
            if (!r_first_vld) begin
              r_first_err <= {r_x, r_y};
              r_first_vld <= 1'b1;
            end
          end
          if (r_idx == 8'hFF) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end else begin
            r_idx <= r_idx + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign X_o             = r_x;
  assign Y_o             = r_y;
  assign busy_o          = r_busy;
  assign done_o          = r_done;
  assign pass_o          = r_done && (r_err_cnt == '0);
  assign err_cnt_o       = r_err_cnt;
  assign first_err_o     = r_first_err;
  assign first_err_vld_o = r_first_vld;

endmodule

// File: tb/tb_comp_4_exerciser.sv
// Bench: delayed behavioural comparator with selectable fault modes, plus a
// second instance (ERR_W=4, SETTLE_CYC=1) fed a stuck-00 responder.
module tb_comp_4_exerciser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, start2 = 1'b0;

  logic [3:0] x1, y1, x2, y2;
  logic       k1 = 1'b0, l1 = 1'b0;
  logic       k2 = 1'b0, l2 = 1'b0;
  logic       busy1, done1, pass1, fev1;
  logic       busy2, done2, pass2, fev2;
  logic [8:0] err1;
  logic [3:0] err2;
  logic [7:0] fe1, fe2;

  int n_chk = 0, n_fail = 0;
  int mode = 0;
  bit         bad [256];
  logic [1:0] badcode [256];
  logic [7:0] hist [0:1] = '{8'd0, 8'd0};

  always #5 clk = ~clk;

  comp_4_exerciser #(.SETTLE_CYC(2), .ERR_W(9)) dut (
    .clk(clk), .rst(rst), .start_i(start), .X_o(x1), .Y_o(y1),
    .K_i(k1), .L_i(l1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
    .err_cnt_o(err1), .first_err_o(fe1), .first_err_vld_o(fev1)
  );

  comp_4_exerciser #(.SETTLE_CYC(1), .ERR_W(4)) dut2 (
    .clk(clk), .rst(rst), .start_i(start2), .X_o(x2), .Y_o(y2),
    .K_i(k2), .L_i(l2), .busy_o(busy2), .done_o(done2), .pass_o(pass2),
    .err_cnt_o(err2), .first_err_o(fe2), .first_err_vld_o(fev2)
  );

  function automatic logic [1:0] ideal(input logic [7:0] v);
    int x, y;
    x = int'(v) / 16;
    y = int'(v) % 16;
    if (x > y) return 2'b10;
    if (x < y) return 2'b01;
    return 2'b11;
  endfunction

  function automatic logic [1:0] resp(input logic [7:0] v);
    logic [1:0] g;
    g = ideal(v);
    case (mode)
      1:       return {1'b1, g[0]};
      2:       return {g[1], 1'b0};
      default: return bad[v] ? badcode[v] : g;
    endcase
  endfunction

  // Responder answers only once the operands have been stable for SETTLE_CYC
  // cycles; an exerciser sampling early sees the previous vector's answer.
  always @(negedge clk) begin
    hist[0]  <= {x1, y1};
    hist[1]  <= hist[0];
    {k1, l1} <= resp(hist[1]);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model(input int sat, output int e_err, output int e_first);
    e_err   = 0;
    e_first = 0;
    for (int v = 0; v < 256; v++) begin
      if (resp(8'(v)) != ideal(8'(v))) begin
        if (e_err == 0) e_first = v;
        if (e_err < sat) e_err++;
      end
    end
  endtask

  task automatic run1(input bit extra, output int cyc);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("start_busy", busy1, 1);
    chk("start_done", done1, 0);
    chk("start_err",  err1,  0);
    cyc = 0;
    while (cyc < 5000) begin
      @(posedge clk); cyc++; #1;
      if (done1) break;
      if (cyc == 10) chk("mid_busy", busy1, 1);
      start = (extra && cyc < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start = 1'b0;
    chk("run_done", done1, 1);
    chk("run_busy_low", busy1, 0);
  endtask

  task automatic check_result(input string tag, input int cyc);
    int e_err, e_first;
    model(511, e_err, e_first);
    chk({tag, "_cycles"}, cyc, 1024);
    chk({tag, "_err"}, err1, e_err);
    chk({tag, "_pass"}, pass1, (e_err == 0));
    chk({tag, "_fvld"}, fev1, (e_err != 0));
    if (e_err != 0) chk({tag, "_first"}, fe1, e_first);
    chk({tag, "_xy"}, {x1, y1}, 8'hFF);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 256; i++) begin bad[i] = 1'b0; badcode[i] = 2'b00; end

    // reset dominates a concurrently asserted start
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_xy",   {x1, y1}, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_pass", pass1, 0);
    chk("rst_err",  err1, 0);
    chk("rst_fe",   {fev1, fe1}, 0);
    chk("rst2",     {busy2, done2, pass2, err2, fev2}, 0);
    start = 1'b0;
    rst   = 1'b0;

    mode = 0; run1(0, cyc); check_result("ideal", cyc);

    mode = 1; run1(0, cyc); check_result("k_hi", cyc);
    chk("k_hi_120", err1, 120);
    chk("k_hi_first01", fe1, 8'h01);

    // restart directly from DONE with a non-zero count pending
    mode = 2; run1(0, cyc); check_result("l_lo", cyc);
    chk("l_lo_136", err1, 136);
    chk("l_lo_first00", fe1, 8'h00);

    // random fault maps, with stray start pulses while busy
    for (int it = 0; it < 3; it++) begin
      mode = 0;
      for (int i = 0; i < 256; i++) begin
        bad[i]     = ($urandom_range(0, 7) == 0);
        badcode[i] = 2'($urandom_range(0, 3));
      end
      run1(1, cyc); check_result("rand", cyc);
    end

    // reset mid-run while X=3, Y=7
    for (int i = 0; i < 256; i++) bad[i] = 1'b0;
    mode = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (!(x1 == 4'd3 && y1 == 4'd7) && cyc < 3000) begin
      @(posedge clk); cyc++; #1;
    end
    chk("mid_reach", {x1, y1}, 8'h37);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("mid_rst_out", {x1, y1, busy1, done1, pass1, err1, fev1, fe1}, 0);
    repeat (4) @(posedge clk);
    #1 chk("mid_rst_idle", busy1, 0);
    run1(0, cyc); check_result("post_rst", cyc);

    // saturating counter on the narrow instance, stuck-00 responder
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    cyc = 0;
    while (cyc < 5000) begin
      @(posedge clk); cyc++; #1;
      if (done2) break;
    end
    chk("sat_cycles", cyc, 768);
    chk("sat_err",    err2, 15);
    chk("sat_first",  fe2, 8'h00);
    chk("sat_fvld",   fev2, 1);
    chk("sat_pass",   pass2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/comp_4_exerciser.md
Name: comp_4_exerciser

Overview:
- Active initiator for the 4-bit magnitude-comparator interface: the block that drives that interface rather than answers it.
- Drives X/Y operand vectors into a COMP_4-style responder and samples its K/L result code.
- Checks every K/L result against the golden encoding, counts mismatches and reports pass/fail.
- Used as on-chip self-test of the comparator path; sweeps all 256 operand pairs per run.

Parameters:
- SETTLE_CYC, 2, cycles from vector drive to K/L sample; legal 1..15.
- ERR_W, 9, mismatch counter width; counter saturates at 2^ERR_W-1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  level; sampled in IDLE or DONE to begin a run.
- X_o  out  4  operand A to comparator; bit 3 is MSB.
- Y_o  out  4  operand B to comparator; bit 3 is MSB.
- K_i  in  1  comparator K result.
- L_i  in  1  comparator L result.
- busy_o  out  1  run in progress.
- done_o  out  1  run complete; held until restart or reset.
- pass_o  out  1  valid when done_o=1; 1 iff err_cnt_o==0.
- err_cnt_o  out  ERR_W  mismatch count.
- first_err_o  out  8  {X,Y} of the first mismatching vector.
- first_err_vld_o  out  1  first_err_o holds a captured value.

Behaviour:
- Interface and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: every output 0, X_o=Y_o=0, state IDLE. Reset overrides start_i.
- Reset mid-run aborts on the next edge. No partial result is kept.
- Golden code:
  - X>Y gives K=1, L=0.
  - X<Y gives K=0, L=1.
  - X==Y gives K=1, L=1.
  - K=0, L=0 is never legal and always counts as a mismatch.
- Vector index: 8-bit idx. X_o=idx[7:4], Y_o=idx[3:0], both registered outputs. idx runs 0x00..0xFF once per run and never wraps into a second pass.
- FSM states: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE:
  - start_i=1 → APPLY.
  - On that edge: idx=0, err_cnt=0, first_err_vld=0, busy_o=1.
- APPLY (1 cycle): X_o/Y_o take idx; settle counter loads SETTLE_CYC-1 → SETTLE.
- SETTLE: counter decrements; at 0 → CHECK.
- CHECK (1 cycle):
  - Sample K_i/L_i and compare with the golden code for the current X_o/Y_o.
  - On mismatch: err_cnt++ (saturating).
  - On the first mismatch only: capture first_err_o and set first_err_vld_o.
  - If idx==0xFF → DONE. Otherwise idx++ → APPLY.
- Timing:
  - K/L are sampled SETTLE_CYC cycles after X_o/Y_o change.
  - Each vector takes SETTLE_CYC+2 cycles.
  - A run is 256*(SETTLE_CYC+2) cycles from the start edge to the done_o rise (1024 at default).
- DONE:
  - busy_o=0, done_o=1, pass_o=(err_cnt==0).
  - X_o/Y_o hold 0xF/0xF. err_cnt_o and first_err_o hold their values.
  - start_i=1 → same actions as from IDLE; done_o and pass_o drop on that edge.
- start_i outside IDLE/DONE is ignored.
- Outputs err_cnt_o, first_err_o and first_err_vld_o are live during the run.

Decomposition:
- Package comp_4_pkg:
  - K/L code constants: KL_GT=2'b10, KL_LT=2'b01, KL_EQ=2'b11, KL_BAD=2'b00.
  - FSM state encoding.
  - Vector width constant (4).
- Sub-module comp_4_ref: purely combinational golden model, X,Y → expected {K,L}. It is reused by benches as the scoreboard.

Test Plan:
1. Ideal COMP_4 attached, SETTLE_CYC=2, start pulse → done_o rises 1024 cycles after the start edge, pass_o=1, err_cnt_o=0, first_err_vld_o=0.
2. K_i tied 1, L_i from ideal comparator → err_cnt_o=120 (all X<Y), first_err_o=8'h01, pass_o=0.
3. L_i tied 0, K_i from ideal comparator → err_cnt_o=136 (X<Y plus X==Y), first_err_o=8'h00.
4. rst asserted one cycle while X_o=3, Y_o=7 → next edge all outputs 0 and state IDLE; a new start completes with pass_o=1.
5. Extra start pulses during busy → run length stays 1024 cycles; start in DONE → restart, err_cnt_o cleared, done_o low on that edge.
6. ERR_W=4, K_i=L_i=0 → 256 mismatches, err_cnt_o saturates at 15, first_err_o=8'h00, pass_o=0.
